iopad_bidir_xfer: RTL
=====================

# iopad_bidir_xfer

Core-side half-duplex serial engine for a single bidirectional pad. It drives the pad cell's `I`, `OEN` and `REN` pins and samples its `C` pin. A word is accepted from the core and shifted out on the pad. The engine can then release the line and capture a response word from the off-chip device. It sits between the capture control logic and the pad-cell wrapper instance in the top level.

## Interface
Parameters:
- `DATA_W`, default 8: word width, both directions.
- `BIT_DIV`, default 16: clocks per bit period. Must be even and ≥ 4.
- `TURN_BITS`, default 2: released bit periods between the end of TX and the start of RX hunt.
- `RX_TIMEOUT`, default 64: bit periods allowed in RX hunt before an error is reported.

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `tx_valid`  in  1: request to transfer.
- `tx_ready`  out  1: high only in IDLE.
- `tx_data`  in  DATA_W: word to send, MSB first.
- `rx_en`  in  1: a response is expected. Sampled with `tx_data`.
- `rx_valid`  out  1: one-cycle pulse when the response completes or times out.
- `rx_data`  out  DATA_W: received word. Held until the next `rx_valid`.
- `rx_err`  out  1: qualifies `rx_valid`. 1 means timeout.
- `busy`  out  1: high in any state other than IDLE.
- `pad_i`  out  1: to the pad cell `I` pin.
- `pad_oen`  out  1: to the pad cell `OEN` pin. 0 means drive.
- `pad_ren`  out  1: to the pad cell `REN` pin. 0 enables the pull, holding the line low when released.
- `pad_c`  in  1: from the pad cell `C` pin. Asynchronous to `clk`.

## Operation
- Reset values:
  - `tx_ready`=1 after reset release.
  - `rx_valid`=0, `rx_data`=0, `rx_err`=0, `busy`=0.
  - `pad_i`=0, `pad_oen`=1, `pad_ren`=0.
  - State IDLE. All counters 0.
- Handshake: a transfer is accepted when `tx_valid && tx_ready`. `tx_data` and `rx_en` are latched on that cycle. `tx_valid` is ignored while `busy` is high.
- States:
  - IDLE: transitions to TX on accept.
  - TX: drives `pad_oen`=0 and `pad_ren`=1. Sends a frame of DATA_W+2 bits: start bit = 1, DATA_W data bits MSB first, stop bit = 0. Each bit lasts BIT_DIV cycles. At the end of the frame, goes to TURN if `rx_en`=1, otherwise to IDLE.
  - TURN: releases the line (`pad_oen`=1, `pad_ren`=0, `pad_i`=0) for TURN_BITS*BIT_DIV cycles, then goes to HUNT.
  - HUNT: waits for synchronized `pad_c`=1.
    - On detecting it, goes to RX_START.
    - After RX_TIMEOUT*BIT_DIV cycles in HUNT without detection, goes to DONE with error. The timeout counter is not reset by a rejected start.
  - RX_START: waits BIT_DIV/2 cycles, then re-samples.
    - Still 1: go to RX.
    - 0: glitch; return to HUNT.
  - RX: samples DATA_W bits at bit centers, spaced BIT_DIV cycles apart, shifting MSB first. After the last sample, goes to DONE.
  - DONE: lasts one cycle.
    - `rx_valid`=1.
    - `rx_err`=1 with `rx_data`=0 on timeout; otherwise `rx_err`=0 with the received word.
    - Then goes to IDLE.
- The line is released in every state except TX.
- A reset at any point, including mid-TX, releases the pad within the same cycle (asynchronous) and discards any partial word.

## Timing
- If an accept occurs in cycle T:
  - `pad_oen` is 0 from T+1 through T+(DATA_W+2)*BIT_DIV.
  - With `rx_en`=0, `tx_ready` is back at 1 in T+(DATA_W+2)*BIT_DIV+1.
- `pad_c` passes through a 2-flop synchronizer (2-cycle latency) before any use.
- Start detection: first synchronized high, plus BIT_DIV/2 cycles to the confirm sample. Data bit k is sampled (k+1)*BIT_DIV cycles after the confirm sample.
- `rx_valid` is asserted on the cycle after the last data sample.
- Counters: the bit-period counter is ceil(log2(BIT_DIV)) bits and wraps to 0 at BIT_DIV−1. The timeout counter saturates at its terminal count and never wraps.

## Structure
- The shared package `iopad_xfer_pkg` holds:
  - the state encodings as localparams: IDLE, TX, TURN, HUNT, RX_START, RX, DONE;
  - the frame constants: START_BIT=1, STOP_BIT=0.
- One sub-module, `sync_bit_2ff`, is the 2-flop synchronizer for `pad_c`, reset to 0.
- Everything else (FSM, shifters, counters) lives in the top module.

## Test plan
All scenarios use the default parameters.
- Send `tx_data`=0xA5 with `rx_en`=0.
  - Expected: the pad shows 1,1,0,1,0,0,1,0,1,0, 16 cycles per bit, with `pad_oen` low for 160 cycles.
  - `tx_ready` returns at T+161 and `rx_valid` never pulses.
- Send `tx_data`=0x01 with `rx_en`=1; the device model answers 0x3C.
  - Expected: `rx_valid`=1 for one cycle, `rx_data`=0x3C, `rx_err`=0.
- Send with `rx_en`=1 and the device model silent.
  - Expected: `rx_valid` with `rx_err`=1 and `rx_data`=0 after 64*16 cycles in HUNT, then IDLE.
- Inject a 5-cycle high glitch in HUNT, followed by a valid 0x81 response.
  - Expected: the glitch is rejected and `rx_data`=0x81.
- Assert `rst_n`=0 at cycle 50 of TX.
  - Expected: `pad_oen`=1, `pad_ren`=0 and `busy`=0 immediately. The next transfer completes normally.
- Hold `tx_valid`=1 with a new value during `busy`.
  - Expected: the new value is ignored until IDLE, then accepted on the first cycle of `tx_ready`.

Source files
------------

// File: rtl/iopad_xfer_pkg.sv
// Shared definitions for the bidirectional pad transfer engine:
// FSM state encodings and serial frame constants.
package iopad_xfer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t TX       = 3'd1;
    localparam state_t TURN     = 3'd2;
    localparam state_t HUNT     = 3'd3;
    localparam state_t RX_START = 3'd4;
    localparam state_t RX       = 3'd5;
    localparam state_t DONE     = 3'd6;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/sync_bit_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset to 0.
// Ports: clk, rst_n (async active-low), d_i (async in), q_o (synced out).
module sync_bit_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/iopad_bidir_xfer.sv
// Half-duplex serial engine for one bidirectional pad: sends a framed
// word, optionally releases the line and captures a response word.
// Ports: clk/rst_n; tx_valid/tx_ready/tx_data/rx_en (core request);
// rx_valid/rx_data/rx_err (response); busy; pad_i/pad_oen/pad_ren/pad_c.
module iopad_bidir_xfer
    import iopad_xfer_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_DIV    = 16,
    parameter int TURN_BITS  = 2,
    parameter int RX_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              rx_en,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_err,
    output logic              busy,
    output logic              pad_i,
    output logic              pad_oen,
    output logic              pad_ren,
    input  logic              pad_c
);

    localparam int FW     = DATA_W + 2;
    localparam int CW     = $clog2(BIT_DIV);
    localparam int IW     = $clog2(FW + TURN_BITS + 1);
    localparam int TO_CYC = RX_TIMEOUT * BIT_DIV;
    localparam int TW     = $clog2(TO_CYC);

    localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_DIV / 2 - 1);
    localparam logic [IW-1:0] TX_LAST   = IW'(FW - 1);
    localparam logic [IW-1:0] TURN_LAST = IW'(TURN_BITS - 1);
    localparam logic [IW-1:0] RX_LAST   = IW'(DATA_W - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     bidx_q, bidx_d;
    logic [TW-1:0]     to_q, to_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic              rx_en_q, rx_en_d;
    logic [DATA_W-2:0] sh_q, sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_err_q, rx_err_d;
    logic [DATA_W-1:0] sh_next;
    logic              c_s;
    logic              bit_end;

    sync_bit_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pad_c),
        .q_o   (c_s)
    );

    assign bit_end = (cnt_q == CNT_LAST);
    assign sh_next = {sh_q, c_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (tx_valid) state_d = TX;
            TX:       if (bit_end && bidx_q == TX_LAST)
                          state_d = rx_en_q ? TURN : IDLE;
            TURN:     if (bit_end && bidx_q == TURN_LAST) state_d = HUNT;
            // A detection in the terminal cycle still wins over the timeout.
            HUNT:     if (c_s) state_d = RX_START;
                      else if (to_q == TO_LAST) state_d = DONE;
            RX_START: if (cnt_q == HALF_LAST) state_d = c_s ? RX : HUNT;
            RX:       if (bit_end && bidx_q == RX_LAST) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_ready = 1'b0;
        busy     = 1'b1;
        rx_valid = 1'b0;
        pad_oen  = 1'b1;
        pad_ren  = 1'b0;
        pad_i    = 1'b0;
        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            TX: begin
                pad_oen = 1'b0;
                pad_ren = 1'b1;
                pad_i   = frame_q[FW-1];
            end
            DONE:    rx_valid = 1'b1;
            default: ;
        endcase
    end

    assign rx_data = rx_data_q;
    assign rx_err  = rx_err_q;

    always_comb begin
        cnt_d     = '0;
        bidx_d    = bidx_q;
        to_d      = to_q;
        frame_d   = frame_q;
        rx_en_d   = rx_en_q;
        sh_d      = sh_q;
        rx_data_d = rx_data_q;
        rx_err_d  = rx_err_q;
        case (state_q)
            IDLE: begin
                bidx_d = '0;
                to_d   = '0;
                if (tx_valid) begin
                    frame_d = {START_BIT, tx_data, STOP_BIT};
                    rx_en_d = rx_en;
                end
            end
            TX: begin
                cnt_d = bit_end ? '0 : cnt_q + CW'(1);
                if (bit_end) begin
                    frame_d = frame_q << 1;
                    bidx_d  = (bidx_q == TX_LAST) ? '0 : bidx_q + IW'(1);
                end
            end
            TURN: begin
                cnt_d = bit_end ? '0 : cnt_q + CW'(1);
                if (bit_end)
                    bidx_d = (bidx_q == TURN_LAST) ? '0 : bidx_q + IW'(1);
            end
            HUNT: begin
                bidx_d = '0;
                if (to_q != TO_LAST) to_d = to_q + TW'(1);
                if (!c_s && to_q == TO_LAST) begin
                    rx_data_d = '0;
                    rx_err_d  = 1'b1;
                end
            end
            RX_START: begin
                cnt_d = (cnt_q == HALF_LAST) ? '0 : cnt_q + CW'(1);
            end
            RX: begin
                cnt_d = bit_end ? '0 : cnt_q + CW'(1);
                if (bit_end) begin
                    sh_d   = sh_next[DATA_W-2:0];
                    bidx_d = bidx_q + IW'(1);
                    if (bidx_q == RX_LAST) begin
                        rx_data_d = sh_next;
                        rx_err_d  = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bidx_q    <= '0;
            to_q      <= '0;
            frame_q   <= '0;
            rx_en_q   <= 1'b0;
            sh_q      <= '0;
            rx_data_q <= '0;
            rx_err_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bidx_q    <= bidx_d;
            to_q      <= to_d;
            frame_q   <= frame_d;
            rx_en_q   <= rx_en_d;
            sh_q      <= sh_d;
            rx_data_q <= rx_data_d;
            rx_err_q  <= rx_err_d;
        end
    end

endmodule
